output_argmax: RTL and testbench
================================

OUTPUT_ARGMAX -- requirements
Module: output_argmax

Interface
REQ-001 Parameter MARGIN, default 16'd64, minimum best-minus-second score for a confident decision.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  one-cycle strobe; S0..S9 valid this cycle.
REQ-005 S0..S9  input  16 each  output-layer neuron scores (post-ReLU), unsigned.
REQ-006 class_idx  output  4  index of winning score, registered.
REQ-007 class_score  output  16  winning score, registered.
REQ-008 low_conf  output  1  winning margin below MARGIN, registered.
REQ-009 out_valid  output  1  one-cycle pulse; class_idx/class_score/low_conf updated.
REQ-010 busy  output  1  high while a frame is held (SCAN or DONE).
REQ-011 overrun  output  1  sticky; in_valid arrived while busy.

Function
REQ-012 FSM states IDLE, SCAN, DONE; all state and outputs change only on rising clk.
REQ-013 IDLE with in_valid=1 at edge E0: capture S0..S9 into a 10-entry register bank, best<=S0, best_idx<=0, second<=0, ptr<=1, go SCAN.
REQ-014 IDLE with in_valid=0: hold; outputs keep last values.
REQ-015 SCAN, one index per edge (E1..E9, ptr 1..9): if cap[ptr] > best: second<=best, best<=cap[ptr], best_idx<=ptr; else if cap[ptr] > second: second<=cap[ptr].
REQ-016 SCAN: ptr increments by 1; edge processing ptr=9 moves to DONE (no wrap past 9).
REQ-017 DONE at edge E10: class_idx<=best_idx, class_score<=best, low_conf<=((best-second) < MARGIN), out_valid<=1, go IDLE.
REQ-018 out_valid is 1 for exactly the cycle after E10, 0 otherwise; latency in_valid->out_valid fixed 10 edges.
REQ-019 Comparisons are unsigned 16-bit; best-second never underflows (best >= second invariant).
REQ-020 Ties: strict > for best, so lowest index among equal maxima wins; duplicated maximum yields margin 0.
REQ-021 busy = 1 in SCAN and DONE, 0 in IDLE (registered state decode).
REQ-022 in_valid in SCAN or DONE: frame dropped, captured bank unchanged, overrun<=1.
REQ-023 overrun cleared only by reset.
REQ-024 Earliest next accepted in_valid is edge E11; sustained throughput one frame per 11 cycles.

Reset
REQ-025 reset=1 at an edge: state<=IDLE, class_idx<=0, class_score<=0, low_conf<=0, out_valid<=0, overrun<=0, ptr<=0, best/second/bank<=0.
REQ-026 Reset has priority over in_valid and over any in-flight scan; aborted frame produces no out_valid.
REQ-027 First edge after reset deasserts is a normal IDLE edge; in_valid there is accepted.

Verification
REQ-028 S=(10,20,300,40,5,6,7,8,9,11), in_valid 1 cycle -> 10 edges later out_valid pulse, class_idx=2, class_score=300, low_conf=0.
REQ-029 S=(100,500,500,0,...,0) -> class_idx=1, class_score=500, low_conf=1 (margin 0).
REQ-030 S=(0,...,0,1000 at S9), S8=950 -> class_idx=9, class_score=1000, low_conf=1 (margin 50 < 64); S8=900 -> low_conf=0.
REQ-031 in_valid at E0 and again at E5 -> single out_valid for E0 frame with E0 data, overrun=1 and stays 1 until reset.
REQ-032 in_valid at E0, reset at E4 -> no out_valid, busy=0, all outputs 0 after E4; new in_valid at E5 completes normally at E15.
REQ-033 Back-to-back frames with in_valid at E0 and E11 -> two out_valid pulses (after E10, E21), overrun=0.

Source files
------------

// File: rtl/output_argmax.sv
`default_nettype none
// ============================================================================
// Module   : output_argmax
// Purpose  : Picks the winning class from ten unsigned 16-bit output-layer
//            scores. It captures a frame, then scans it one entry per clock
//            while tracking the best and second-best scores. It reports the
//            winning index and score, and flags a low-confidence decision
//            when (best - second) is below MARGIN. Latency from in_valid to
//            out_valid is 10 edges. One frame is accepted every 11 cycles.
// Ports    : clk          - rising-edge clock
//            reset        - synchronous, active-high reset
//            in_valid     - one-cycle strobe, S0..S9 valid this cycle
//            S0..S9       - neuron scores (unsigned, post-ReLU)
//            class_idx    - index of the winning score (registered)
//            class_score  - winning score (registered)
//            low_conf     - winning margin below MARGIN (registered)
//            out_valid    - one-cycle pulse when the three results update
//            busy         - a frame is held (SCAN or DONE)
//            overrun      - sticky: in_valid arrived while busy
// Revision : 1.0 - initial release
// ============================================================================
module output_argmax #(
  parameter logic [15:0] MARGIN = 16'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] S0,
  input  logic [15:0] S1,
  input  logic [15:0] S2,
  input  logic [15:0] S3,
  input  logic [15:0] S4,
  input  logic [15:0] S5,
  input  logic [15:0] S6,
  input  logic [15:0] S7,
  input  logic [15:0] S8,
  input  logic [15:0] S9,
  output logic [3:0]  class_idx,
  output logic [15:0] class_score,
  output logic        low_conf,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_last_idx = 4'd9;

  state_t      state_q, state_d;
  logic [15:0] cap_q [10];
  logic [15:0] cap_d [10];
  logic [15:0] best_q, best_d;
  logic [15:0] second_q, second_d;
  logic [3:0]  best_idx_q, best_idx_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  class_idx_q, class_idx_d;
  logic [15:0] class_score_q, class_score_d;
  logic        low_conf_q, low_conf_d;
  logic        out_valid_q, out_valid_d;
  logic        overrun_q, overrun_d;

  logic [15:0] s_in [10];
  logic [15:0] scan_val;
  logic [15:0] margin;

  always_comb begin
    s_in[0] = S0;
    s_in[1] = S1;
    s_in[2] = S2;
    s_in[3] = S3;
    s_in[4] = S4;
    s_in[5] = S5;
    s_in[6] = S6;
    s_in[7] = S7;
    s_in[8] = S8;
    s_in[9] = S9;
  end

  // Entry of the captured bank under inspection this cycle.
  always_comb begin
    scan_val = '0;
    for (int i = 0; i < 10; i++) begin
      if (ptr_q == 4'(i)) scan_val = cap_q[i];
    end
  end

  // best >= second always holds, so this subtraction cannot wrap.
  assign margin = best_q - second_q;

  always_comb begin
    state_d       = state_q;
    cap_d         = cap_q;
    best_d        = best_q;
    second_d      = second_q;
    best_idx_d    = best_idx_q;
    ptr_d         = ptr_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    low_conf_d    = low_conf_q;
    out_valid_d   = 1'b0;
    overrun_d     = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cap_d      = s_in;
          best_d     = S0;
          best_idx_d = 4'd0;
          second_d   = 16'd0;
          ptr_d      = 4'd1;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Strict '>' keeps the lowest index among equal maxima; an equal
        // value still lands in second, so a duplicated maximum gives margin 0.
        if (scan_val > best_q) begin
          second_d   = best_q;
          best_d     = scan_val;
          best_idx_d = ptr_q;
        end else if (scan_val > second_q) begin
          second_d = scan_val;
        end
        if (ptr_q == c_last_idx) begin
          ptr_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end
      ST_DONE: begin
        class_idx_d   = best_idx_q;
        class_score_d = best_q;
        low_conf_d    = (margin < MARGIN);
        out_valid_d   = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A strobe during SCAN or DONE is dropped; only the flag records it.
    if (in_valid && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < 10; i++) cap_q[i] <= '0;
      best_q        <= '0;
      second_q      <= '0;
      best_idx_q    <= '0;
      ptr_q         <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      low_conf_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cap_q         <= cap_d;
      best_q        <= best_d;
      second_q      <= second_d;
      best_idx_q    <= best_idx_d;
      ptr_q         <= ptr_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      low_conf_q    <= low_conf_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;
  assign low_conf    = low_conf_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_output_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_argmax
// Purpose  : Self-checking bench for output_argmax. A frame-level model
//            predicts all outputs every cycle: a frame accepted at edge k
//            reports at edge k+10, and strobes that arrive while a frame is
//            held set overrun. Directed frames also pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_argmax;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] drv_s [10];
  logic [3:0]  class_idx;
  logic [15:0] class_score;
  logic        low_conf, out_valid, busy, overrun;

  always #5 clk = ~clk;

  output_argmax #(.MARGIN(16'd64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .S0(drv_s[0]), .S1(drv_s[1]), .S2(drv_s[2]), .S3(drv_s[3]), .S4(drv_s[4]),
    .S5(drv_s[5]), .S6(drv_s[6]), .S7(drv_s[7]), .S8(drv_s[8]), .S9(drv_s[9]),
    .class_idx(class_idx), .class_score(class_score), .low_conf(low_conf),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int          edge_n = 0;
  int          acc_edge = 0;
  bit          pending = 0;
  logic [15:0] m_frame [10];
  logic [31:0] e_idx = 0, e_score = 0;
  logic        e_low = 0, e_ov = 0, e_ovr = 0, e_busy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Top-two of the frame as a multiset; the winner is the first index
  // holding the maximum, the runner-up is the largest of the others.
  task automatic top2(output int idx, output int b, output int sec);
    b = 0;
    for (int i = 0; i < 10; i++) if (int'(m_frame[i]) > b) b = int'(m_frame[i]);
    idx = 0;
    for (int i = 9; i >= 0; i--) if (int'(m_frame[i]) == b) idx = i;
    sec = 0;
    for (int i = 0; i < 10; i++)
      if (i != idx && int'(m_frame[i]) > sec) sec = int'(m_frame[i]);
  endtask

  // One clock: apply inputs, advance the model at the edge, compare after it.
  task automatic cyc(input logic iv, input logic rst);
    bit was_busy;
    int idx, b, sec;
    in_valid = iv;
    reset    = rst;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      pending = 0; e_idx = 0; e_score = 0; e_low = 0; e_ov = 0; e_ovr = 0;
    end else begin
      was_busy = pending;
      e_ov = 0;
      if (pending && edge_n == acc_edge + 10) begin
        top2(idx, b, sec);
        e_idx = idx; e_score = b; e_low = ((b - sec) < 64); e_ov = 1;
        pending = 0;
      end
      if (iv) begin
        if (was_busy) e_ovr = 1;
        else begin
          pending = 1; acc_edge = edge_n; m_frame = drv_s;
        end
      end
    end
    e_busy = pending;
    #1;
    chk("out_valid",   {31'd0, out_valid}, {31'd0, e_ov});
    chk("busy",        {31'd0, busy},      {31'd0, e_busy});
    chk("overrun",     {31'd0, overrun},   {31'd0, e_ovr});
    chk("class_idx",   {28'd0, class_idx}, e_idx);
    chk("class_score", {16'd0, class_score}, e_score);
    chk("low_conf",    {31'd0, low_conf},  {31'd0, e_low});
  endtask

  task automatic set_s(input int a0, input int a1, input int a2, input int a3,
                       input int a4, input int a5, input int a6, input int a7,
                       input int a8, input int a9);
    drv_s[0] = 16'(a0); drv_s[1] = 16'(a1); drv_s[2] = 16'(a2); drv_s[3] = 16'(a3);
    drv_s[4] = 16'(a4); drv_s[5] = 16'(a5); drv_s[6] = 16'(a6); drv_s[7] = 16'(a7);
    drv_s[8] = 16'(a8); drv_s[9] = 16'(a9);
  endtask

  // Idle cycles until out_valid, bounded; k = cycles taken (99 = timeout).
  task automatic wait_out(output int k);
    k = 99;
    for (int i = 1; i <= 14; i++) begin
      cyc(1'b0, 1'b0);
      if (out_valid === 1'b1) begin k = i; break; end
    end
    if (k == 99) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic lit(input string nm, input int idx, input int score, input int low);
    chk({nm, "_idx"},   {28'd0, class_idx},   32'(idx));
    chk({nm, "_score"}, {16'd0, class_score}, 32'(score));
    chk({nm, "_low"},   {31'd0, low_conf},    32'(low));
    chk({nm, "_model_idx"}, e_idx, 32'(idx));
    chk({nm, "_model_low"}, {31'd0, e_low}, 32'(low));
  endtask

  initial begin
    int k;
    in_valid = 0; reset = 1;
    set_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("reset_idx",   {28'd0, class_idx},   32'd0);
    chk("reset_score", {16'd0, class_score}, 32'd0);
    chk("reset_busy",  {31'd0, busy},        32'd0);

    // Clear winner; in_valid on the first edge after reset.
    set_s(10, 20, 300, 40, 5, 6, 7, 8, 9, 11);
    cyc(1'b1, 1'b0);
    wait_out(k);
    chk("latency_a", 32'(k), 32'd10);
    lit("frame_a", 2, 300, 0);

    // Duplicated maximum: lowest index wins, margin 0.
    set_s(100, 500, 500, 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0);
    wait_out(k);
    lit("frame_dup", 1, 500, 1);

    // Winner at the last index, margin 50 then 100.
    set_s(0, 0, 0, 0, 0, 0, 0, 0, 950, 1000);
    cyc(1'b1, 1'b0);
    wait_out(k);
    lit("frame_m50", 9, 1000, 1);
    set_s(0, 0, 0, 0, 0, 0, 0, 0, 900, 1000);
    cyc(1'b1, 1'b0);
    wait_out(k);
    lit("frame_m100", 9, 1000, 0);

    // Overrun: second strobe at E5 is dropped, E0 data reported.
    set_s(10, 20, 300, 40, 5, 6, 7, 8, 9, 11);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    set_s(9000, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    cyc(1'b1, 1'b0);
    wait_out(k);
    chk("overrun_latency", 32'(k), 32'd5);
    lit("frame_ovr", 2, 300, 0);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    cyc(1'b0, 1'b1);
    chk("overrun_cleared", {31'd0, overrun}, 32'd0);

    // Reset aborts an in-flight frame at E4; a new frame at E5 completes.
    set_s(10, 20, 300, 40, 5, 6, 7, 8, 9, 11);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    set_s(0, 0, 0, 0, 0, 0, 0, 0, 900, 1000);
    cyc(1'b1, 1'b0);
    wait_out(k);
    chk("abort_latency", 32'(k), 32'd10);
    lit("frame_abort", 9, 1000, 0);

    // Back-to-back at E0 and E11.
    set_s(1, 2, 3, 4, 5, 6, 7, 8, 9, 700);
    cyc(1'b1, 1'b0);
    wait_out(k);
    lit("b2b_first", 9, 700, 0);
    set_s(800, 2, 3, 4, 5, 6, 7, 8, 9, 10);
    cyc(1'b1, 1'b0);
    wait_out(k);
    chk("b2b_latency", 32'(k), 32'd10);
    lit("b2b_second", 0, 800, 0);
    chk("b2b_overrun", {31'd0, overrun}, 32'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      logic iv, rst;
      int mode;
      iv   = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 149) == 0);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 10; i++) begin
        case (mode)
          0: drv_s[i] = 16'($urandom);
          1: drv_s[i] = 16'($urandom_range(0, 7));
          default: drv_s[i] = 16'(1000 + $urandom_range(0, 100));
        endcase
      end
      cyc(iv, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
